dmem_wbuf: RTL and testbench
============================

# dmem_wbuf

Data-memory access unit between the execute stage's memory port and the synchronous data RAM. It absorbs stores into a DEPTH-entry posted write buffer, drained to RAM in the background. Loads are served in the same cycle when the buffer covers all four bytes. Otherwise a load is fetched from RAM and merged with buffered bytes, with `hold_flag_o` stalling the pipeline until the data is ready.

## Interface
- `DEPTH`, 4: write-buffer entries; power of two, ≥2.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `mem_req_i` input 1: access request from execute, one access per cycle.
- `mem_we_i` input 1: 1 = store, 0 = load; qualified by `mem_req_i`.
- `mem_waddr_i` input 32: store byte address; bits [1:0] ignored.
- `mem_wdata_i` input 32: store data, lane-aligned.
- `mem_wmask_i` input 4: store byte enables; bit n enables byte n.
- `mem_raddr_i` input 32: load byte address; bits [1:0] ignored; returns the full word.
- `mem_rdata_o` output 32: load data; valid in any cycle where a load is requested and `hold_flag_o` = 0.
- `hold_flag_o` output 1: stall request to the pipeline. Execute keeps all `mem_*_i` stable while it is high.
- `wbuf_empty_o` output 1: buffer empty and no RAM write in flight (used for fence).
- `ram_req_o` output 1: RAM request; registered; held until `ram_gnt_i`.
- `ram_we_o` output 1: RAM write.
- `ram_addr_o` output 32: RAM word address, with bits [1:0] = 0.
- `ram_wdata_o` output 32: RAM write data.
- `ram_wmask_o` output 4: RAM byte enables.
- `ram_gnt_i` input 1: RAM accepts the request this cycle.
- `ram_rvalid_i` input 1: read data valid; arrives one or more cycles after the read grant.
- `ram_rdata_i` input 32: RAM read data.

## Operation
- **Buffer**: circular FIFO of {word address, data, mask}, with a registered count from 0 to DEPTH.
  - Push: on `mem_req_i & mem_we_i` when count < DEPTH.
  - Pop: on a drain grant.
  - No full-bypass: when count = DEPTH, a push is refused even if a pop happens in the same cycle.
  - Simultaneous push and pop leaves count unchanged.
- **Forwarding**: combinational, for loads.
  - Compare `mem_raddr_i[31:2]` against every valid entry.
  - Per byte, the youngest matching entry with that mask bit set supplies the byte.
  - Hit = all four bytes are supplied by the buffer.
- **FSM**: states IDLE, DRAIN, RD_REQ, RD_WAIT.
  - IDLE, load miss: register the read onto the RAM port (`ram_we_o` = 0), then go to RD_REQ.
  - IDLE, otherwise with count > 0: register the head entry onto the RAM port, then go to DRAIN.
  - IDLE, otherwise: stay in IDLE.
  - A load miss has priority over draining.
  - DRAIN: keep `ram_req_o` = 1 until `ram_gnt_i`. On grant: pop, drop `ram_req_o`, go to IDLE.
  - RD_REQ: keep `ram_req_o` = 1 until `ram_gnt_i`. On grant: drop `ram_req_o`, go to RD_WAIT.
  - RD_WAIT: on `ram_rvalid_i`, `mem_rdata_o` = `ram_rdata_i` merged with the forwarded bytes (buffer bytes win), then go to IDLE.
- **hold_flag_o** (combinational) = a store with count = DEPTH, OR a load that is not a forwarding hit and not (RD_WAIT & `ram_rvalid_i`).
  - A load arriving during DRAIN is held until the drain completes; the miss is then issued from IDLE.
- **Stores during DRAIN/RD_\***: accepted whenever count < DEPTH.
  - A stalled load blocks the execute stage, so no store can arrive during RD_REQ/RD_WAIT.
- **mem_rdata_o**:
  - Forwarded word on a hit.
  - Merged word in the RD_WAIT + rvalid cycle.
  - 0 otherwise.
- **wbuf_empty_o** = (count = 0) & (state ≠ DRAIN).
- **Reset** (any cycle, including mid-transaction):
  - count 0, pointers 0, state IDLE.
  - All `ram_*_o` = 0.
  - `hold_flag_o` = 0, `mem_rdata_o` = 0, `wbuf_empty_o` = 1.
  - Any outstanding RAM transaction is abandoned; the RAM shares `rst`.

## Timing
- Store, not full: 0 stall cycles. Visible to forwarding from the next cycle.
- Drain latency: head entry appears on `ram_*_o` the cycle after IDLE with count > 0. Pop occurs in the grant cycle.
- Load hit: data in the same cycle, no hold.
- Load miss from IDLE, with grant one cycle after issue and rvalid one cycle after grant:
  - Cycle 0: hold.
  - Cycle 1: `ram_req_o` = 1 and granted; hold.
  - Cycle 2: rvalid; data out, hold = 0.
- Full buffer: the store is held until the first pop. It is accepted in the cycle after the pop, when count = DEPTH−1.
- Count saturates at DEPTH. Pointers wrap modulo DEPTH.

## Test plan
- **Reset mid-drain**: assert `rst` while `ram_req_o` = 1 → all outputs return to reset values immediately; `wbuf_empty_o` = 1.
- **Full forwarding**: store 0xDEADBEEF (mask 1111) to 0x100, then load 0x100 next cycle → `mem_rdata_o` = 0xDEADBEEF, `hold_flag_o` = 0, no RAM read issued.
- **Partial merge**: store 0x000000AA (mask 0001) to 0x200, RAM holds 0x11223344, load 0x200 with RAM gnt/rvalid at +1/+1 → hold for 2 cycles, then `mem_rdata_o` = 0x112233AA.
- **Youngest wins**: store 0x11 (mask 0001) then 0x22 (mask 0001) to 0x300, then load with RAM = 0 → byte 0 = 0x22.
- **Full back-pressure**: 5 back-to-back stores with `ram_gnt_i` held low → 4 accepted, `hold_flag_o` = 1 on the 5th. Raise gnt → the 5th is accepted the cycle after the first pop. The RAM receives the writes in program order.
- **Load during drain**: issue a load miss while in DRAIN with gnt delayed 3 cycles → hold until the drain grant. The read is issued afterwards, and the RAM sees the write before the read.

Source files
------------

// File: rtl/dmem_wbuf_if.sv
// dmem_wbuf_if
//   Groups the execute-stage memory port and the data-RAM port of the
//   data-memory access unit into one bundle.
//
//   Execute side : mem_req_i, mem_we_i, mem_waddr_i, mem_wdata_i, mem_wmask_i,
//                  mem_raddr_i (in); mem_rdata_o, hold_flag_o, wbuf_empty_o (out)
//   RAM side     : ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o (out);
//                  ram_gnt_i, ram_rvalid_i, ram_rdata_i (in)
//   Debug        : dbg_state_o, the current control FSM state.
//
//   Handshakes:
//   - Execute -> unit: mem_req_i presents one access per cycle. hold_flag_o
//     acts as an inverted ready. An access completes in a cycle where
//     mem_req_i = 1 and hold_flag_o = 0. While hold_flag_o = 1, the source
//     keeps every mem_*_i stable.
//   - Unit -> RAM: ram_req_o acts as valid and ram_gnt_i as ready. A request
//     transfers in a cycle where both are 1. ram_req_o and its payload stay
//     stable until that cycle. Read data returns later, qualified by
//     ram_rvalid_i.
//
//   The slave modport is the dmem_wbuf view. The master modport is the view of
//   the surrounding pipeline and RAM.
interface dmem_wbuf_if;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wmask_i;
    logic [31:0] mem_raddr_i;
    logic [31:0] mem_rdata_o;
    logic        hold_flag_o;
    logic        wbuf_empty_o;
    logic        ram_req_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [3:0]  ram_wmask_o;
    logic        ram_gnt_i;
    logic        ram_rvalid_i;
    logic [31:0] ram_rdata_i;
    logic [1:0]  dbg_state_o;

    modport slave (
        input  mem_req_i, mem_we_i, mem_waddr_i, mem_wdata_i, mem_wmask_i, mem_raddr_i,
        output mem_rdata_o, hold_flag_o, wbuf_empty_o,
        output ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
        input  ram_gnt_i, ram_rvalid_i, ram_rdata_i,
        output dbg_state_o
    );

    modport master (
        output mem_req_i, mem_we_i, mem_waddr_i, mem_wdata_i, mem_wmask_i, mem_raddr_i,
        input  mem_rdata_o, hold_flag_o, wbuf_empty_o,
        input  ram_req_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_wmask_o,
        output ram_gnt_i, ram_rvalid_i, ram_rdata_i,
        input  dbg_state_o
    );
endinterface

// File: rtl/dmem_wbuf.sv
// dmem_wbuf
//   Data-memory access unit with a DEPTH-entry posted write buffer.
//   - Stores go into a circular FIFO and drain to RAM in the background.
//   - Loads are answered in the same cycle when buffered stores cover all
//     four bytes.
//   - Otherwise the word is read from RAM, and buffered bytes are merged over
//     it. hold_flag_o stalls execute until the data is ready.
//
//   Ports:
//     clk - clock, rising edge
//     rst - asynchronous active-high reset (shared with the RAM)
//     bus - dmem_wbuf_if.slave (execute port, RAM port, FSM debug state)
module dmem_wbuf #(
    parameter int DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    dmem_wbuf_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRAIN   = 2'd1;
    localparam logic [1:0] S_RD_REQ  = 2'd2;
    localparam logic [1:0] S_RD_WAIT = 2'd3;

    // Buffer storage; validity is implied by count/rd_ptr, so no reset needed.
    logic [29:0] ent_addr_q [DEPTH];
    logic [31:0] ent_data_q [DEPTH];
    logic [3:0]  ent_mask_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;

    logic        ram_req_q, ram_req_d;
    logic        ram_we_q, ram_we_d;
    logic [31:0] ram_addr_q, ram_addr_d;
    logic [31:0] ram_wdata_q, ram_wdata_d;
    logic [3:0]  ram_wmask_q, ram_wmask_d;

    logic        is_store, is_load, buf_full;
    logic        push, pop;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_bmask;
    logic [31:0] fwd_wmask;
    logic        fwd_hit, load_miss;
    logic        rd_done;
    logic [31:0] merged_word;
    logic [31:0] rdata;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{bus.mem_waddr_i[1:0], bus.mem_raddr_i[1:0]};

    assign is_store = bus.mem_req_i & bus.mem_we_i;
    assign is_load  = bus.mem_req_i & ~bus.mem_we_i;
    assign buf_full = (count_q == CNT_W'(DEPTH));

    // A full buffer refuses a push even when an entry pops this cycle.
    assign push = is_store & ~buf_full;
    assign pop  = (state_q == S_DRAIN) & bus.ram_gnt_i;

    // Store-to-load forwarding. Walk from the oldest entry to the youngest,
    // so a later match overwrites an earlier one byte by byte.
    always_comb begin
        logic [PTR_W-1:0] slot;
        fwd_data  = 32'h0;
        fwd_bmask = 4'h0;
        slot      = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            slot = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (ent_addr_q[slot] == bus.mem_raddr_i[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (ent_mask_q[slot][b]) begin
                        fwd_data[8*b +: 8] = ent_data_q[slot][8*b +: 8];
                        fwd_bmask[b]       = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        fwd_wmask = 32'h0;
        for (int b = 0; b < 4; b++) begin
            fwd_wmask[8*b +: 8] = {8{fwd_bmask[b]}};
        end
    end

    assign fwd_hit     = is_load & (fwd_bmask == 4'hF);
    assign load_miss   = is_load & ~fwd_hit;
    assign rd_done     = (state_q == S_RD_WAIT) & bus.ram_rvalid_i;
    // Buffered bytes are younger than the RAM copy, so they win.
    assign merged_word = (bus.ram_rdata_i & ~fwd_wmask) | fwd_data;

    always_comb begin
        rdata = 32'h0;
        if (fwd_hit) begin
            rdata = fwd_data;
        end else if (rd_done) begin
            rdata = merged_word;
        end
    end

    // Control FSM and registered RAM port.
    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_wmask_d = ram_wmask_q;
        unique case (state_q)
            S_IDLE: begin
                // A waiting load outranks background draining.
                if (load_miss) begin
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = {bus.mem_raddr_i[31:2], 2'b00};
                    ram_wdata_d = 32'h0;
                    ram_wmask_d = 4'h0;
                    state_d     = S_RD_REQ;
                end else if (count_q != '0) begin
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = {ent_addr_q[rd_ptr_q], 2'b00};
                    ram_wdata_d = ent_data_q[rd_ptr_q];
                    ram_wmask_d = ent_mask_q[rd_ptr_q];
                    state_d     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.ram_gnt_i) begin
                    ram_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (bus.ram_gnt_i) begin
                    ram_req_d = 1'b0;
                    state_d   = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.ram_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                ram_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Pointers and count.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 32'h0;
            ram_wdata_q <= 32'h0;
            ram_wmask_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wmask_q <= ram_wmask_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q] <= bus.mem_waddr_i[31:2];
            ent_data_q[wr_ptr_q] <= bus.mem_wdata_i;
            ent_mask_q[wr_ptr_q] <= bus.mem_wmask_i;
        end
    end

    assign bus.hold_flag_o  = (is_store & buf_full) | (is_load & ~fwd_hit & ~rd_done);
    assign bus.mem_rdata_o  = rdata;
    assign bus.wbuf_empty_o = (count_q == '0) & (state_q != S_DRAIN);
    assign bus.ram_req_o    = ram_req_q;
    assign bus.ram_we_o     = ram_we_q;
    assign bus.ram_addr_o   = ram_addr_q;
    assign bus.ram_wdata_o  = ram_wdata_q;
    assign bus.ram_wmask_o  = ram_wmask_q;
    assign bus.dbg_state_o  = state_q;
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf
//   Directed bench for dmem_wbuf.
//   - A behavioural RAM grants after a programmable delay and returns read
//     data one cycle after the grant.
//   - Every RAM write is compared in order against exp_q.
//   - Load data and stall lengths are compared against hand-computed values.
module tb_dmem_wbuf;
    localparam int W = 68;  // {addr[31:0], wdata[31:0], wmask[3:0]}

    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [31:0]  ram_mem [logic [29:0]];
    bit           ops_q[$];  // 1 = write, 0 = read, in RAM acceptance order
    int           gnt_delay = 0;
    int           wait_cnt  = 0;
    int           wr_cnt    = 0;
    int           rd_cnt    = 0;

    logic        s_req, s_gnt, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_mask;

    dmem_wbuf_if bus();

    dmem_wbuf #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [29:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
    endfunction

    // ---------------- RAM model ----------------
    initial begin
        bus.ram_gnt_i    = 1'b0;
        bus.ram_rvalid_i = 1'b0;
        bus.ram_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            s_req   = bus.ram_req_o;
            s_gnt   = bus.ram_gnt_i;
            s_we    = bus.ram_we_o;
            s_addr  = bus.ram_addr_o;
            s_wdata = bus.ram_wdata_o;
            s_mask  = bus.ram_wmask_o;
            @(posedge clk);
            #1;
            bus.ram_rvalid_i = 1'b0;
            bus.ram_rdata_i  = 32'h0;
            if (rst) begin
                bus.ram_gnt_i = 1'b0;
                wait_cnt      = 0;
            end else begin
                if (s_req && s_gnt) begin
                    if (s_we) begin
                        logic [31:0] word;
                        word = ram_rd(s_addr[31:2]);
                        for (int b = 0; b < 4; b++) begin
                            if (s_mask[b]) word[8*b +: 8] = s_wdata[8*b +: 8];
                        end
                        ram_mem[s_addr[31:2]] = word;
                        wr_cnt++;
                        ops_q.push_back(1'b1);
                        if (exp_q.size() == 0) begin
                            check_val("ram_wr_unexpected", W'(exp_q.size()), W'(1));
                        end else begin
                            check_val("ram_wr_order", {s_addr, s_wdata, s_mask}, exp_q.pop_front());
                        end
                    end else begin
                        bus.ram_rvalid_i = 1'b1;
                        bus.ram_rdata_i  = ram_rd(s_addr[31:2]);
                        rd_cnt++;
                        ops_q.push_back(1'b0);
                    end
                end
                if (bus.ram_req_o) begin
                    bus.ram_gnt_i = (wait_cnt >= gnt_delay);
                    wait_cnt++;
                end else begin
                    bus.ram_gnt_i = 1'b0;
                    wait_cnt      = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_waddr_i = 32'h0;
        bus.mem_wdata_i = 32'h0;
        bus.mem_wmask_i = 4'h0;
        bus.mem_raddr_i = 32'h0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        bit ok;
        ok = 1'b0;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_waddr_i = addr;
        bus.mem_wdata_i = data;
        bus.mem_wmask_i = mask;
        exp_q.push_back({addr & 32'hFFFF_FFFC, data, mask});
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!bus.hold_flag_o) ok = 1'b1;
            tick();
        end
        if (!ok) check_val("store_timeout", W'(ok), W'(1));
        bus_idle();
    endtask

    task automatic do_load(input logic [31:0] addr, output logic [31:0] data, output int holds);
        bit ok;
        ok    = 1'b0;
        holds = 0;
        data  = 32'h0;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b0;
        bus.mem_raddr_i = addr;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (!bus.hold_flag_o) begin
                ok   = 1'b1;
                data = bus.mem_rdata_o;
            end else begin
                holds++;
            end
            tick();
        end
        if (!ok) check_val("load_timeout", W'(ok), W'(1));
        bus_idle();
    endtask

    task automatic wait_empty(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.wbuf_empty_o) ok = 1'b1;
        end
        check_val(tag, W'(ok), W'(1));
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        int          h;
        int          base;
        bit          ok;

        rst = 1'b1;
        bus_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ram_req", W'(bus.ram_req_o), W'(0));
        check_val("rst_hold", W'(bus.hold_flag_o), W'(0));
        check_val("rst_rdata", W'(bus.mem_rdata_o), W'(0));
        check_val("rst_empty", W'(bus.wbuf_empty_o), W'(1));
        rst = 1'b0;
        tick();

        // Full forwarding: hit in the cycle after the store, no RAM read.
        base = rd_cnt;
        do_store(32'h100, 32'hDEAD_BEEF, 4'hF);
        do_load(32'h100, d, h);
        check_val("fwd_data", W'(d), W'(32'hDEAD_BEEF));
        check_val("fwd_holds", W'(h), W'(0));
        check_val("fwd_no_rd", W'(rd_cnt - base), W'(0));
        wait_empty("fwd_drain");
        // Same word now comes from RAM: issue, grant, rvalid.
        do_load(32'h100, d, h);
        check_val("ram_rd_data", W'(d), W'(32'hDEAD_BEEF));
        check_val("ram_rd_holds", W'(h), W'(2));

        // Partial merge of a buffered byte over RAM data.
        ram_mem[30'h80] = 32'h1122_3344;
        do_store(32'h200, 32'h0000_00AA, 4'h1);
        do_load(32'h200, d, h);
        check_val("merge_data", W'(d), W'(32'h1122_33AA));
        check_val("merge_holds", W'(h), W'(2));
        wait_empty("merge_drain");
        check_val("merge_ram", W'(ram_rd(30'h80)), W'(32'h1122_33AA));

        // Youngest entry supplies the byte; the load arrives while draining.
        ram_mem[30'hC0] = 32'h0;
        do_store(32'h300, 32'h0000_0011, 4'h1);
        do_store(32'h300, 32'h0000_0022, 4'h1);
        do_load(32'h300, d, h);
        check_val("young_data", W'(d), W'(32'h0000_0022));
        check_val("young_holds", W'(h), W'(3));
        wait_empty("young_drain");
        check_val("young_ram", W'(ram_rd(30'hC0)), W'(32'h0000_0022));

        // Full back-pressure: the fifth store stalls until one entry pops.
        gnt_delay = 1000;
        base      = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            bus.mem_req_i   = 1'b1;
            bus.mem_we_i    = 1'b1;
            bus.mem_waddr_i = 32'h400 + 32'(4 * i);
            bus.mem_wdata_i = 32'hC0DE_0000 + 32'(i);
            bus.mem_wmask_i = 4'hF;
            exp_q.push_back({32'h400 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF});
            @(negedge clk);
            check_val($sformatf("bp_hold%0d", i), W'(bus.hold_flag_o), W'(i == 4));
            if (i < 4) tick();
        end
        check_val("bp_not_empty", W'(bus.wbuf_empty_o), W'(0));
        gnt_delay = 0;
        ok = 1'b0;
        for (int j = 0; j < 50 && !ok; j++) begin
            tick();
            @(negedge clk);
            if (!bus.hold_flag_o) ok = 1'b1;
        end
        check_val("bp_accept", W'(ok), W'(1));
        check_val("bp_pop_first", W'(wr_cnt - base), W'(1));
        tick();
        bus_idle();
        wait_empty("bp_drain");
        check_val("bp_writes", W'(wr_cnt - base), W'(5));

        // Load miss arriving during DRAIN with a slow grant.
        gnt_delay = 3;
        ram_mem[30'h140] = 32'h5566_7788;
        do_store(32'h600, 32'h1234_5678, 4'hF);
        tick();
        ops_q.delete();
        do_load(32'h500, d, h);
        check_val("ld_drain_data", W'(d), W'(32'h5566_7788));
        check_val("ld_drain_holds", W'(h), W'(9));
        check_val("ld_drain_nops", W'(ops_q.size()), W'(2));
        if (ops_q.size() == 2) begin
            check_val("ld_drain_first_wr", W'(ops_q[0]), W'(1));
            check_val("ld_drain_then_rd", W'(ops_q[1]), W'(0));
        end
        gnt_delay = 0;
        wait_empty("ld_drain_empty");

        // Reset while a drain request is outstanding.
        gnt_delay = 1000;
        do_store(32'h700, 32'h7777_7777, 4'hF);
        tick();
        @(negedge clk);
        check_val("pre_rst_req", W'(bus.ram_req_o), W'(1));
        check_val("pre_rst_we", W'(bus.ram_we_o), W'(1));
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_req", W'(bus.ram_req_o), W'(0));
        check_val("mid_rst_we", W'(bus.ram_we_o), W'(0));
        check_val("mid_rst_addr", W'(bus.ram_addr_o), W'(0));
        check_val("mid_rst_wdata", W'(bus.ram_wdata_o), W'(0));
        check_val("mid_rst_empty", W'(bus.wbuf_empty_o), W'(1));
        check_val("mid_rst_hold", W'(bus.hold_flag_o), W'(0));
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        gnt_delay = 0;
        tick();
        // The abandoned entry must be gone: this load goes to RAM.
        do_load(32'h700, d, h);
        check_val("post_rst_data", W'(d), W'(32'h0));
        check_val("post_rst_holds", W'(h), W'(2));

        check_val("exp_q_drained", W'(exp_q.size()), W'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
